sap_bus_xfer: RTL and testbench

Parametrised register-file and bus-transfer sequencer for the FPGA computer, the next generation of its hand-driven PC/ACC/BREG/ALU bus logic. It holds NREG general registers of WIDTH bits on a shared registered bus. It executes one transfer per request (move, program load, ALU op, clear) through a fixed four-state sequence with a REQ/ACK handshake. An optional debouncer conditions a push-button request.

---
 rtl/sap_bus_xfer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sap_bus_xfer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_bus_xfer.sv
// sap_bus_xfer: register file plus a four-state bus-transfer sequencer.
// Each request runs IDLE -> DRIVE -> WRITE -> DONE and is acknowledged by a
// one-cycle ACK. BUS is a registered copy of the last value driven.
// Optional build macro: SAP_REQ_DEBOUNCE_EN adds a stability filter on REQ.
module sap_bus_xfer #(
    parameter int WIDTH   = 8,
    parameter int NREG    = 4,
    parameter int SEL_W   = 2,
    parameter int DB_BITS = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ,
    input  logic [1:0]       MODE,
    input  logic [2:0]       OP,
    input  logic [SEL_W-1:0] SRC,
    input  logic [SEL_W-1:0] DST,
    input  logic [WIDTH-1:0] PRGM_IN,
    input  logic             HLT,
    input  logic [SEL_W-1:0] VIEW,
    output logic [WIDTH-1:0] BUS,
    output logic [WIDTH-1:0] CURRENT,
    output logic             BUSY,
    output logic             ACK,
    output logic             ERR,
    output logic             CARRY,
    output logic             ZERO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_MOVE  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_ALU   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // Register count at select width + 1 so that NREG == 2**SEL_W fits.
    localparam logic [SEL_W:0] NREG_L = (SEL_W+1)'(NREG);

    if (NREG < 2 || NREG > (1 << SEL_W) || DB_BITS < 1) begin : g_param_check
        $error("sap_bus_xfer: parameter set out of range");
    end

    // ALU result with the carry/borrow flag in the top bit.
    function automatic logic [WIDTH:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] ones;
        logic [WIDTH:0]   res;
        one  = {{(WIDTH-1){1'b0}}, 1'b1};
        ones = {WIDTH{1'b1}};
        case (op)
            3'b000:  res = {1'b0, a} + {1'b0, b};
            3'b001:  res = {(a < b), a - b};
            3'b010:  res = {(a == {WIDTH{1'b0}}), a - one};
            3'b011:  res = {(a == ones), a + one};
            3'b100:  res = {1'b0, ~a};
            3'b101:  res = {1'b0, a & b};
            3'b110:  res = {1'b0, a | b};
            3'b111:  res = {1'b0, a ^ b};
            default: res = {(WIDTH+1){1'b0}};
        endcase
        return res;
    endfunction

    state_t           state_r, state_next_s;
    logic             req_q_r;
    logic             req_cond_s;
    logic             start_s;
    logic             err_in_s;

    logic [1:0]       mode_r;
    logic [2:0]       op_r;
    logic [SEL_W-1:0] src_r;
    logic [SEL_W-1:0] dst_r;
    logic [WIDTH-1:0] prgm_r;
    logic             err_pend_r;

    logic [WIDTH-1:0] regs_r [NREG];
    logic [WIDTH-1:0] bus_r;
    logic             carry_r;
    logic             zero_r;
    logic             carry_pend_r;
    logic             busy_r;
    logic             ack_r;
    logic             err_r;

    logic [WIDTH:0]   alu_s;
    logic [WIDTH-1:0] src_val_s;
    logic [WIDTH-1:0] current_s;

`ifdef SAP_REQ_DEBOUNCE_EN
    logic               req_sync_r;
    logic               db_req_r;
    logic [DB_BITS-1:0] db_cnt_r;

    // Sample raw REQ, then flip the filtered level only after it has disagreed for a full count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_sync_r <= 1'b0;
            db_req_r   <= 1'b0;
            db_cnt_r   <= {DB_BITS{1'b0}};
        end else begin
            req_sync_r <= REQ;
            if (req_sync_r == db_req_r) begin
                db_cnt_r <= {DB_BITS{1'b0}};
            end else if (&db_cnt_r) begin
                db_req_r <= req_sync_r;
                db_cnt_r <= {DB_BITS{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DB_BITS'(1);
            end
        end
    end

    assign req_cond_s = db_req_r;
`else
    assign req_cond_s = REQ;
`endif

    assign start_s  = req_cond_s & ~req_q_r & (state_r == ST_IDLE);
    assign err_in_s = ({1'b0, DST} >= NREG_L) ||
                      ((MODE == MODE_MOVE) && ({1'b0, SRC} >= NREG_L));

    // Edge-detect history; keeps running during HLT so edges seen then are dropped.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_q_r <= 1'b0;
        end else begin
            req_q_r <= req_cond_s;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fixed IDLE->DRIVE->WRITE->DONE ring; HLT holds the current state.
    always_comb begin
        state_next_s = state_r;
        if (HLT) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_next_s = ST_DRIVE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DRIVE: state_next_s = ST_WRITE;
                ST_WRITE: state_next_s = ST_DONE;
                ST_DONE:  state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Source selection for the DRIVE cycle; ALU operands are always R0 and R1.
    always_comb begin
        alu_s     = alu_eval(op_r, regs_r[0], regs_r[1]);
        src_val_s = {WIDTH{1'b0}};
        case (mode_r)
            MODE_MOVE:  src_val_s = regs_r[src_r];
            MODE_LOAD:  src_val_s = prgm_r;
            MODE_ALU:   src_val_s = alu_s[WIDTH-1:0];
            MODE_CLEAR: src_val_s = {WIDTH{1'b0}};
            default:    src_val_s = {WIDTH{1'b0}};
        endcase
    end

    // Status outputs registered from the next state so they line up with it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_r <= 1'b0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            ack_r  <= (state_next_s == ST_DONE);
            err_r  <= (state_next_s == ST_DONE) && err_pend_r;
        end
    end

    // Capture, bus drive, register write-back and flag update; all frozen by HLT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mode_r       <= 2'b00;
            op_r         <= 3'b000;
            src_r        <= {SEL_W{1'b0}};
            dst_r        <= {SEL_W{1'b0}};
            prgm_r       <= {WIDTH{1'b0}};
            err_pend_r   <= 1'b0;
            bus_r        <= {WIDTH{1'b0}};
            carry_pend_r <= 1'b0;
            carry_r      <= 1'b0;
            zero_r       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else if (!HLT) begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        mode_r     <= MODE;
                        op_r       <= OP;
                        src_r      <= SRC;
                        dst_r      <= DST;
                        prgm_r     <= PRGM_IN;
                        err_pend_r <= err_in_s;
                    end
                end
                ST_DRIVE: begin
                    if (!err_pend_r) begin
                        bus_r        <= src_val_s;
                        carry_pend_r <= alu_s[WIDTH];
                    end
                end
                ST_WRITE: begin
                    if (!err_pend_r) begin
                        regs_r[dst_r] <= bus_r;
                        if (mode_r == MODE_ALU) begin
                            carry_r <= carry_pend_r;
                            zero_r  <= (bus_r == {WIDTH{1'b0}});
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register viewer; out-of-range selects read as zero.
    always_comb begin
        current_s = {WIDTH{1'b0}};
        if ({1'b0, VIEW} < NREG_L) begin
            current_s = regs_r[VIEW];
        end else begin
            current_s = {WIDTH{1'b0}};
        end
    end

    assign BUS     = bus_r;
    assign CURRENT = current_s;
    assign BUSY    = busy_r;
    assign ACK     = ack_r;
    assign ERR     = err_r;
    assign CARRY   = carry_r;
    assign ZERO    = zero_r;

endmodule

// File: tb/tb_sap_bus_xfer.sv
// Bench for sap_bus_xfer (NREG=3 so select value 3 is an invalid register).
// Directed vector table, hand-written HLT/RESET/REQ-edge sequences and a
// randomized phase checked against a small behavioural model.
module tb_sap_bus_xfer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ;
    logic [1:0] MODE;
    logic [2:0] OP;
    logic [1:0] SRC;
    logic [1:0] DST;
    logic [7:0] PRGM_IN;
    logic       HLT;
    logic [1:0] VIEW;
    logic [7:0] BUS;
    logic [7:0] CURRENT;
    logic       BUSY;
    logic       ACK;
    logic       ERR;
    logic       CARRY;
    logic       ZERO;

`ifdef SAP_REQ_DEBOUNCE_EN
    localparam int LAT = 20;
    localparam int GAP = 20;
`else
    localparam int LAT = 3;
    localparam int GAP = 1;
`endif

    sap_bus_xfer #(.WIDTH(8), .NREG(3), .SEL_W(2), .DB_BITS(4)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .MODE(MODE), .OP(OP),
        .SRC(SRC), .DST(DST), .PRGM_IN(PRGM_IN), .HLT(HLT), .VIEW(VIEW),
        .BUS(BUS), .CURRENT(CURRENT), .BUSY(BUSY), .ACK(ACK), .ERR(ERR),
        .CARRY(CARRY), .ZERO(ZERO)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_regs [3];
    int m_bus, m_c, m_z;

    typedef struct {
        int m; int o; int s; int d; int p;
        int bus; int err; int c; int z;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_reg(input int v);
        if (v < 3) return m_regs[v];
        return 0;
    endfunction

    task automatic check_regs(input string tag);
        for (int v = 0; v < 4; v++) begin
            VIEW = 2'(v);
            #1;
            check($sformatf("%s CURRENT[%0d]", tag, v), int'(CURRENT), model_reg(v));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = 0;
        m_bus = 0; m_c = 0; m_z = 0;
    endtask

    // Transfer semantics from the rules: value by mode, ALU on R0/R1, flags only for ALU.
    task automatic model_apply(input int m, input int o, input int s, input int d, input int p,
                               output int eb, output int ee, output int ec, output int ez);
        int a, b, r, c;
        a = m_regs[0];
        b = m_regs[1];
        r = 0;
        c = 0;
        ee = ((d >= 3) || (m == 0 && s >= 3)) ? 1 : 0;
        if (ee == 0) begin
            case (m)
                0: r = m_regs[s];
                1: r = p;
                2: begin
                    case (o)
                        0: begin r = a + b; c = (r > 255) ? 1 : 0; end
                        1: begin r = a - b; c = (a < b) ? 1 : 0; end
                        2: begin r = a - 1; c = (a == 0) ? 1 : 0; end
                        3: begin r = a + 1; c = (a == 255) ? 1 : 0; end
                        4: r = 255 - a;
                        5: r = a & b;
                        6: r = a | b;
                        default: r = a ^ b;
                    endcase
                    r = r & 255;
                end
                default: r = 0;
            endcase
            m_bus = r;
            m_regs[d] = r;
            if (m == 2) begin
                m_c = c;
                m_z = (r == 0) ? 1 : 0;
            end
        end
        eb = m_bus; ec = m_c; ez = m_z;
    endtask

    task automatic add_vec(input int m, input int o, input int s, input int d, input int p,
                           input int bus, input int err, input int c, input int z);
        vec_t v;
        v.m = m; v.o = o; v.s = s; v.d = d; v.p = p;
        v.bus = bus; v.err = err; v.c = c; v.z = z;
        vecs.push_back(v);
    endtask

    // One full transfer: raise REQ, observe BUS/ACK timing, then drop REQ.
    task automatic run_xfer(input string tag, input int m, input int o, input int s, input int d,
                            input int p, input int eb, input int ee, input int ec, input int ez);
        int acks, ack_at, err_seen, c_seen, z_seen, bus_seen, busy_after;
        MODE = 2'(m); OP = 3'(o); SRC = 2'(s); DST = 2'(d); PRGM_IN = 8'(p);
        REQ = 1'b1;
        acks = 0; ack_at = -1; err_seen = -1; c_seen = -1; z_seen = -1;
        bus_seen = -1; busy_after = -1;
        for (int e = 1; e <= LAT + 3; e++) begin
            @(posedge CLK); #1;
            if (e == LAT - 1) bus_seen = int'(BUS);
            if (e == LAT + 1) busy_after = int'(BUSY);
            if (ACK) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = e; err_seen = int'(ERR);
                    c_seen = int'(CARRY); z_seen = int'(ZERO);
                end
            end
        end
        REQ = 1'b0;
        check({tag, " bus"}, bus_seen, eb);
        check({tag, " ack count"}, acks, 1);
        check({tag, " ack cycle"}, ack_at, LAT);
        check({tag, " err"}, err_seen, ee);
        check({tag, " carry"}, c_seen, ec);
        check({tag, " zero"}, z_seen, ez);
        check({tag, " busy after"}, busy_after, 0);
        repeat (GAP) begin @(posedge CLK); #1; end
        check_regs(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int eb, ee, ec, ez, acks, frozen, old_bus;
        RESET = 1'b1; REQ = 1'b0; MODE = 2'b00; OP = 3'b000; SRC = 2'b00; DST = 2'b00;
        PRGM_IN = 8'h00; HLT = 1'b0; VIEW = 2'b00;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // Reset state
        check("reset BUS", int'(BUS), 0);
        check("reset BUSY", int'(BUSY), 0);
        check("reset ACK", int'(ACK), 0);
        check("reset ERR", int'(ERR), 0);
        check("reset CARRY", int'(CARRY), 0);
        check("reset ZERO", int'(ZERO), 0);
        check_regs("reset");

        // Directed table: mode, op, src, dst, prgm -> bus, err, carry, zero
        add_vec(1, 0, 0, 0, 'h5A, 'h5A, 0, 0, 0);
        add_vec(0, 0, 0, 2, 'h00, 'h5A, 0, 0, 0);
        add_vec(1, 0, 0, 0, 'hF0, 'hF0, 0, 0, 0);
        add_vec(1, 0, 0, 1, 'h20, 'h20, 0, 0, 0);
        add_vec(2, 0, 0, 2, 'h00, 'h10, 0, 1, 0);
        add_vec(1, 0, 0, 0, 'h33, 'h33, 0, 1, 0);
        add_vec(1, 0, 0, 1, 'h33, 'h33, 0, 1, 0);
        add_vec(2, 1, 0, 0, 'h00, 'h00, 0, 0, 1);
        add_vec(1, 0, 0, 2, 'hA5, 'hA5, 0, 0, 1);
        add_vec(0, 0, 1, 3, 'h00, 'hA5, 1, 0, 1);
        add_vec(0, 0, 3, 1, 'h00, 'hA5, 1, 0, 1);
        add_vec(3, 0, 0, 1, 'h00, 'h00, 0, 0, 1);
        add_vec(1, 0, 0, 0, 'hFF, 'hFF, 0, 0, 1);
        add_vec(2, 3, 0, 1, 'h00, 'h00, 0, 1, 1);
        add_vec(2, 2, 0, 2, 'h00, 'hFE, 0, 0, 0);
        add_vec(2, 4, 0, 2, 'h00, 'h00, 0, 0, 1);
        add_vec(1, 0, 0, 1, 'h0F, 'h0F, 0, 0, 1);
        add_vec(2, 7, 0, 2, 'h00, 'hF0, 0, 0, 0);
        add_vec(0, 0, 2, 2, 'h00, 'hF0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 'h00, 'h00, 0, 0, 0);
        add_vec(2, 2, 0, 1, 'h00, 'hFF, 0, 1, 0);
        add_vec(2, 0, 0, 0, 'h00, 'hFF, 0, 0, 0);
        add_vec(2, 1, 0, 2, 'h00, 'h00, 0, 0, 1);
        add_vec(2, 5, 0, 2, 'h00, 'hFF, 0, 0, 0);

        foreach (vecs[i]) begin
            model_apply(vecs[i].m, vecs[i].o, vecs[i].s, vecs[i].d, vecs[i].p, eb, ee, ec, ez);
            run_xfer($sformatf("vec%0d", i), vecs[i].m, vecs[i].o, vecs[i].s, vecs[i].d,
                     vecs[i].p, vecs[i].bus, vecs[i].err, vecs[i].c, vecs[i].z);
        end

        // Randomized transfers against the model
        for (int n = 0; n < 40; n++) begin
            int m, o, s, d, p;
            m = int'($urandom_range(3));
            o = int'($urandom_range(7));
            s = int'($urandom_range(3));
            d = (m == 2) ? int'($urandom_range(2)) : int'($urandom_range(3));
            p = int'($urandom_range(255));
            model_apply(m, o, s, d, p, eb, ee, ec, ez);
            run_xfer($sformatf("rnd%0d", n), m, o, s, d, p, eb, ee, ec, ez);
        end

`ifndef SAP_REQ_DEBOUNCE_EN
        // REQ held for many cycles with a re-toggle while busy: one transfer only
        MODE = 2'b01; DST = 2'd0; PRGM_IN = 8'h77; REQ = 1'b1;
        acks = 0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge CLK); #1;
            if (ACK) acks++;
            if (e == 2) REQ = 1'b0;
            if (e == 3) REQ = 1'b1;
        end
        REQ = 1'b0;
        @(posedge CLK); #1;
        check("held req ack count", acks, 1);
        model_apply(1, 0, 0, 0, 'h77, eb, ee, ec, ez);
        check_regs("held req");

        // HLT in DRIVE for 5 cycles, then RESET in WRITE
        old_bus = m_bus;
        MODE = 2'b01; DST = 2'd1; PRGM_IN = 8'h3C; REQ = 1'b1;
        @(posedge CLK); #1;
        HLT = 1'b1;
        check("hlt busy in drive", int'(BUSY), 1);
        frozen = 1;
        repeat (5) begin
            @(posedge CLK); #1;
            if (int'(BUS) != old_bus || !BUSY || ACK) frozen = 0;
        end
        check("hlt frozen", frozen, 1);
        HLT = 1'b0;
        @(posedge CLK); #1;
        check("bus after hlt", int'(BUS), 'h3C);
        #2 RESET = 1'b1;
        #1;
        check("abort BUS", int'(BUS), 0);
        check("abort BUSY", int'(BUSY), 0);
        check("abort ACK", int'(ACK), 0);
        check("abort CARRY", int'(CARRY), 0);
        check("abort ZERO", int'(ZERO), 0);
        REQ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_reset();
        acks = 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (ACK) acks++;
        end
        check("abort no ack", acks, 0);
        check_regs("abort");
`else
        // A 10-cycle glitch must not start a transfer
        MODE = 2'b01; DST = 2'd0; PRGM_IN = 8'h11; REQ = 1'b1;
        repeat (10) @(posedge CLK);
        #1 REQ = 1'b0;
        acks = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (ACK) acks++;
        end
        check("glitch ack count", acks, 0);
        check_regs("glitch");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
